be_dual_port_memory: RTL and testbench

- Parametrised successor to the single-port reset-cleared memory.
- Separate write and read ports, per-byte write enables, and a selectable read latency of 1 or 2 cycles.
- Selectable read-during-write policy.
- Contents are cleared by a sequential sweep FSM, one entry per cycle, so no per-entry reset fan-out is needed. The same sweep is triggered by reset or by a software clear request.
- Sits between a datapath producer (write side) and consumer (read side) as a general scratch RAM.

---
 rtl/be_dual_port_memory.sv | 87 ++++++++
 tb/tb_be_dual_port_memory.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/be_dual_port_memory.sv
// be_dual_port_memory: byte-enabled scratch RAM with separate write/read ports and a sequential clear sweep
module be_dual_port_memory #(
  parameter int WIDTH       = 32,
  parameter int BYTE_W      = 8,
  parameter int DEPTH       = 16,
  parameter int ADDR_WIDTH  = 4,
  parameter int RD_LATENCY  = 1,
  parameter int WRITE_FIRST = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    init_req,
  output logic                    busy,
  input  logic                    we,
  input  logic [ADDR_WIDTH-1:0]   waddr,
  input  logic [WIDTH-1:0]        wdata,
  input  logic [WIDTH/BYTE_W-1:0] wbe,
  input  logic                    re,
  input  logic [ADDR_WIDTH-1:0]   raddr,
  output logic [WIDTH-1:0]        rdata,
  output logic                    rvalid
);
  localparam int NB = WIDTH / BYTE_W;
  localparam logic [ADDR_WIDTH:0]   LIMIT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(DEPTH - 1);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state, state_n;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic idle, wr_in, rd_in, wr_ok, rd_ok;
  logic [WIDTH-1:0] old_word, merged, rd_word;
  assign idle  = state == IDLE && !rst;
  assign wr_in = {1'b0, waddr} < LIMIT;
  assign rd_in = {1'b0, raddr} < LIMIT;
  assign wr_ok = idle && we && !init_req && wr_in;
  assign rd_ok = idle && re;
  assign busy  = rst || state == CLEAR;
  always_ff @(posedge clk) begin
    state <= rst ? CLEAR : state_n;
    ptr   <= (rst || state == IDLE) ? '0 : ptr + 1'b1;
  end
  always_comb begin
    state_n = (state == IDLE) ? (init_req ? CLEAR : IDLE) : (ptr == LAST ? IDLE : CLEAR);
  end
  always_ff @(posedge clk) begin
    if (state == CLEAR && !rst)
      mem[ptr] <= '0;
    else if (wr_ok)
      for (int k = 0; k < NB; k++)
        if (wbe[k]) mem[waddr][k*BYTE_W +: BYTE_W] <= wdata[k*BYTE_W +: BYTE_W];
  end
  // Read data is captured at request time, so in-flight reads keep pre-clear contents.
  always_comb begin
    old_word = rd_in ? mem[raddr] : '0;
    merged   = old_word;
    for (int k = 0; k < NB; k++)
      if (wbe[k]) merged[k*BYTE_W +: BYTE_W] = wdata[k*BYTE_W +: BYTE_W];
    rd_word = (WRITE_FIRST != 0 && wr_ok && waddr == raddr) ? merged : old_word;
  end
  if (RD_LATENCY == 2) begin : g_lat2
    logic p_valid;
    logic [WIDTH-1:0] p_data;
    always_ff @(posedge clk) begin
      if (rst) begin
        p_valid <= 1'b0;
        p_data  <= '0;
        rvalid  <= 1'b0;
        rdata   <= '0;
      end else begin
        p_valid <= rd_ok;
        if (rd_ok) p_data <= rd_word;
        rvalid <= p_valid;
        if (p_valid) rdata <= p_data;
      end
    end
  end else begin : g_lat1
    always_ff @(posedge clk) begin
      if (rst) begin
        rvalid <= 1'b0;
        rdata  <= '0;
      end else begin
        rvalid <= rd_ok;
        if (rd_ok) rdata <= rd_word;
      end
    end
  end
endmodule

// File: tb/tb_be_dual_port_memory.sv
// tb_be_dual_port_memory: directed checks of a latency-1/read-first RAM and a latency-2/write-first 12-entry RAM
module tb_be_dual_port_memory;
  logic clk = 0, rst = 1, init_req = 0, we = 0, re = 0;
  logic [3:0] waddr = 0, raddr = 0, wbe = 0;
  logic [31:0] wdata = 0;
  logic busy_a, busy_b, rvalid_a, rvalid_b;
  logic [31:0] rdata_a, rdata_b;
  logic [31:0] model [16];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  be_dual_port_memory dut_a (
    .clk(clk), .rst(rst), .init_req(init_req), .busy(busy_a),
    .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .re(re), .raddr(raddr), .rdata(rdata_a), .rvalid(rvalid_a)
  );

  be_dual_port_memory #(.DEPTH(12), .RD_LATENCY(2), .WRITE_FIRST(1)) dut_b (
    .clk(clk), .rst(rst), .init_req(init_req), .busy(busy_b),
    .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .re(re), .raddr(raddr), .rdata(rdata_b), .rvalid(rvalid_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    we = 1; waddr = a; wdata = d; wbe = be;
    tick();
    we = 0;
    for (int k = 0; k < 4; k++)
      if (be[k]) model[a][k*8 +: 8] = d[k*8 +: 8];
  endtask

  task automatic rd(input logic [3:0] a, input string tag);
    logic [31:0] eb;
    eb = (a < 12) ? model[a] : 32'h0;
    re = 1; raddr = a;
    tick();
    re = 0;
    check($sformatf("%s_a_valid", tag), rvalid_a, 1);
    check($sformatf("%s_a_data", tag), rdata_a, model[a]);
    tick();
    check($sformatf("%s_b_valid", tag), rvalid_b, 1);
    check($sformatf("%s_b_data", tag), rdata_b, eb);
  endtask

  task automatic sweep(input string tag);
    int fa, fb;
    fa = 0; fb = 0;
    for (int i = 1; i <= 40 && (fa == 0 || fb == 0); i++) begin
      tick();
      if (!busy_a && fa == 0) fa = i;
      if (!busy_b && fb == 0) fb = i;
    end
    check($sformatf("%s_busy_a_cycles", tag), fa, 16);
    check($sformatf("%s_busy_b_cycles", tag), fb, 12);
  endtask

  task automatic read_all_zero(input string tag);
    for (int i = 0; i < 16; i++) model[i] = 0;
    for (int i = 0; i < 16; i++) rd(4'(i), $sformatf("%s%0d", tag, i));
  endtask

  initial begin
    int fa, fb;
    for (int i = 0; i < 16; i++) model[i] = 0;
    tick();
    tick();
    check("rst_busy", busy_a, 1);
    check("rst_rdata", rdata_a, 0);
    check("rst_rvalid", rvalid_a, 0);
    check("rst_rvalid_b", rvalid_b, 0);
    rst = 0;
    sweep("reset");
    read_all_zero("reset_rd");

    wr(3, 32'hAABBCCDD, 4'hF);
    wr(3, 32'h11223344, 4'b0101);
    rd(3, "byte_en");
    check("byte_en_value", rdata_a, 32'hAA22CC44);
    wr(6, 32'h0BAD0BAD, 4'h0);
    rd(6, "wbe_zero");

    wr(1, 32'h1, 4'hF);
    wr(2, 32'h2, 4'hF);
    wr(3, 32'h3, 4'hF);
    for (int i = 0; i < 5; i++) begin
      re = i < 3; raddr = 4'(i + 1);
      tick();
      if (i < 3) begin
        check($sformatf("pipe_a_valid%0d", i), rvalid_a, 1);
        check($sformatf("pipe_a_data%0d", i), rdata_a, 32'(i + 1));
      end else check($sformatf("pipe_a_idle%0d", i), rvalid_a, 0);
      if (i == 0 || i == 4) check($sformatf("pipe_b_idle%0d", i), rvalid_b, 0);
      else begin
        check($sformatf("pipe_b_valid%0d", i), rvalid_b, 1);
        check($sformatf("pipe_b_data%0d", i), rdata_b, 32'(i));
      end
    end
    re = 0;

    we = 1; waddr = 5; wdata = 32'hFFFFFFFF; wbe = 4'b0011; re = 1; raddr = 5;
    tick();
    we = 0; re = 0;
    model[5] = 32'h0000FFFF;
    check("rdw_a_valid", rvalid_a, 1);
    check("rdw_a_old", rdata_a, 32'h0);
    tick();
    check("rdw_b_valid", rvalid_b, 1);
    check("rdw_b_merged", rdata_b, 32'h0000FFFF);
    rd(5, "rdw_follow");

    wr(13, 32'hDEADBEEF, 4'hF);
    rd(13, "oor");
    tick();
    check("hold_a_data", rdata_a, 32'hDEADBEEF);
    check("hold_a_valid", rvalid_a, 0);

    for (int i = 0; i < 16; i++) wr(4'(i), 32'h5A5A5A5A, 4'hF);
    init_req = 1; we = 1; waddr = 0; wdata = 32'h12345678; wbe = 4'hF; re = 1; raddr = 4;
    tick();
    init_req = 0;
    check("clr_rd_a_valid", rvalid_a, 1);
    check("clr_rd_a_data", rdata_a, 32'h5A5A5A5A);
    fa = 0; fb = 0;
    for (int i = 1; i <= 40 && (fa == 0 || fb == 0); i++) begin
      we = i <= 11; re = i <= 11; waddr = 7; raddr = 2; wdata = 32'hFEEDFACE;
      tick();
      if (i == 1) begin
        check("clr_rd_b_valid", rvalid_b, 1);
        check("clr_rd_b_data", rdata_b, 32'h5A5A5A5A);
      end else if (i <= 12) check($sformatf("clr_b_quiet%0d", i), rvalid_b, 0);
      if (i <= 12) check($sformatf("clr_a_quiet%0d", i), rvalid_a, 0);
      if (!busy_a && fa == 0) fa = i;
      if (!busy_b && fb == 0) fb = i;
    end
    we = 0; re = 0;
    check("clr_busy_a_cycles", fa, 16);
    check("clr_busy_b_cycles", fb, 12);
    read_all_zero("clr_rd");

    wr(3, 32'hCAFEF00D, 4'hF);
    rd(3, "pre_mid");
    init_req = 1;
    tick();
    init_req = 0;
    check("init_ignored_busy", busy_a, 1);
    init_req = 1;
    repeat (9) tick();
    init_req = 0;
    rst = 1;
    tick();
    check("mid_rst_busy", busy_a, 1);
    check("mid_rst_rdata", rdata_a, 0);
    check("mid_rst_rvalid", rvalid_a, 0);
    rst = 0;
    sweep("mid_rst");
    read_all_zero("mid_rd");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
